// File: rtl/cpu_pkg.sv
// cpu_pkg: shared PC width, reset vector, pc_t type and instruction alignment constants.
package cpu_pkg;
    localparam int PC_WIDTH = 16;
    localparam logic [PC_WIDTH-1:0] PC_RESET_VECTOR = 16'h0000;
    typedef logic [PC_WIDTH-1:0] pc_t;
    localparam int ALIGN_BYTES = 4;
    localparam int ALIGN_BITS = 2;
endpackage

// File: rtl/en_dff.sv
// en_dff: parameterised register with asynchronous active-low reset and load enable.
module en_dff #(
    parameter int WIDTH = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) q <= RST_VAL;
        else if (en) q <= d;
endmodule

// File: rtl/program_counter.sv
// program_counter: load-enabled PC register for the multicycle CPU.
// Define PC_ALIGN_CHECK_EN to add the sticky `misaligned` flag output.
module program_counter
    import cpu_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VECTOR = PC_RESET_VECTOR
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in,
    input  logic             PCWrite,
`ifdef PC_ALIGN_CHECK_EN
    output logic             misaligned,
`endif
    output logic [WIDTH-1:0] out
);
    en_dff #(.WIDTH(WIDTH), .RST_VAL(RESET_VECTOR)) u_pc (
        .clock(clock), .reset_n(reset_n), .en(PCWrite), .d(in), .q(out)
    );
`ifdef PC_ALIGN_CHECK_EN
    // Only ever written with 1, so once set it stays set until reset.
    en_dff #(.WIDTH(1), .RST_VAL(1'b0)) u_align (
        .clock(clock), .reset_n(reset_n),
        .en(PCWrite && (in[ALIGN_BITS-1:0] != '0)),
        .d(1'b1), .q(misaligned)
    );
`endif
endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter: directed-vector self-checking bench for program_counter.
module tb_program_counter;
    logic        clock = 1'b0;
    logic        reset_n;
    logic [15:0] in;
    logic        PCWrite;
    logic [15:0] out;
    int vectors = 0;
    int miscompares = 0;
`ifdef PC_ALIGN_CHECK_EN
    logic misaligned;
`endif

    program_counter dut (
        .clock(clock),
        .reset_n(reset_n),
        .in(in),
        .PCWrite(PCWrite),
`ifdef PC_ALIGN_CHECK_EN
        .misaligned(misaligned),
`endif
        .out(out)
    );

    task automatic tick;
        #5 clock = 1'b1;
        #5 clock = 1'b0;
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        PCWrite = 1'b1;
        in = 16'hABCD;
        #3 check("reset_no_clock", out, 16'h0000);
        tick;
        check("reset_holds_with_load", out, 16'h0000);
        PCWrite = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) tick;
        check("idle_after_reset", out, 16'h0000);
        in = 16'h0004;
        PCWrite = 1'b1;
        #1 check("no_comb_path", out, 16'h0000);
        tick;
        check("load_0004", out, 16'h0004);
        PCWrite = 1'b0;
        in = 16'h0008;
        for (int i = 0; i < 5; i++) begin
            tick;
            check("hold_0004", out, 16'h0004);
        end
        PCWrite = 1'b1;
        in = 16'hFFFC;
        tick;
        check("load_fffc", out, 16'hFFFC);
        in = 16'h0000;
        tick;
        check("load_wrap_0000", out, 16'h0000);
        in = 16'hFFFF;
        tick;
        check("load_ffff", out, 16'hFFFF);
        in = 16'h1234;
        tick;
        check("load_1234", out, 16'h1234);
        PCWrite = 1'b0;
        #2 reset_n = 1'b0;
        #1 check("async_reset", out, 16'h0000);
        PCWrite = 1'b1;
        in = 16'h0010;
        #1 reset_n = 1'b1;
        #1 check("release_no_edge", out, 16'h0000);
        tick;
        check("first_load_after_reset", out, 16'h0010);
`ifdef PC_ALIGN_CHECK_EN
        reset_n = 1'b0;
        #1 check("mis_reset", {15'b0, misaligned}, 16'h0000);
        reset_n = 1'b1;
        in = 16'h0008;
        tick;
        check("mis_aligned_load", {15'b0, misaligned}, 16'h0000);
        in = 16'h0006;
        tick;
        check("load_0006", out, 16'h0006);
        check("mis_set", {15'b0, misaligned}, 16'h0001);
        in = 16'h0008;
        tick;
        check("load_0008", out, 16'h0008);
        check("mis_sticky", {15'b0, misaligned}, 16'h0001);
        reset_n = 1'b0;
        #1 check("mis_cleared", {15'b0, misaligned}, 16'h0000);
        reset_n = 1'b1;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
